// File: rtl/osnt_rx_port_arbiter_if.sv
// rtl/osnt_rx_port_arbiter_if.sv - AXI4-Stream bundle carrying LANES parallel lanes
interface osnt_rx_port_arbiter_if #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 128,
  parameter int LANES      = 1
) ();
  logic [LANES*DATA_WIDTH-1:0]   tdata;
  logic [LANES*DATA_WIDTH/8-1:0] tkeep;
  logic [LANES*USER_WIDTH-1:0]   tuser;
  logic [LANES-1:0]              tvalid;
  logic [LANES-1:0]              tlast;
  logic [LANES-1:0]              tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/osnt_rx_port_arbiter.sv
// rtl/osnt_rx_port_arbiter.sv - packet-granular round-robin merge of rx queues with per-port discard
module osnt_rx_port_arbiter #(
  parameter int AXI_DATA_WIDTH = 512,
  parameter int AXI_USER_WIDTH = 128,
  parameter int NUM_PORTS      = 4,
  parameter int SRC_PORT_POS   = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  osnt_rx_port_arbiter_if.slave  s_axis,
  osnt_rx_port_arbiter_if.master m_axis,
  input  logic [NUM_PORTS-1:0]   port_enable,
  output logic [NUM_PORTS-1:0]   flush_pulse,
  output logic [2:0]             grant_port,
  output logic                   busy
);
  localparam int DW = AXI_DATA_WIDTH;
  localparam int KW = AXI_DATA_WIDTH / 8;
  localparam int UW = AXI_USER_WIDTH;
  localparam int NP = NUM_PORTS;

  typedef enum logic [1:0] {IDLE, FWD, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    last_grant_q, last_grant_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic          m_tlast_q, m_tlast_d;
  logic [DW-1:0] m_tdata_q, m_tdata_d;
  logic [KW-1:0] m_tkeep_q, m_tkeep_d;
  logic [UW-1:0] m_tuser_q, m_tuser_d;

  logic [NP-1:0] gnt_oh;
  logic [DW-1:0] sel_tdata;
  logic [KW-1:0] sel_tkeep;
  logic [UW-1:0] sel_tuser;
  logic          found_hi, found_lo;
  logic [2:0]    pick_hi, pick_lo, pick;
  logic          pick_en;
  logic          g_valid, g_last, out_load, g_ready, beat_acc;

  // Decode the held grant to one-hot and mux that port's lane
  always_comb begin
    gnt_oh    = '0;
    sel_tdata = '0;
    sel_tkeep = '0;
    sel_tuser = '0;
    for (int p = 0; p < NP; p++) begin
      if (grant_q == p[2:0]) begin
        gnt_oh[p] = 1'b1;
        sel_tdata = s_axis.tdata[p*DW +: DW];
        sel_tkeep = s_axis.tkeep[p*KW +: KW];
        sel_tuser = s_axis.tuser[p*UW +: UW];
      end
    end
  end

  // Round-robin search: lowest valid port above last_grant, else lowest at or below it
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int p = NP - 1; p >= 0; p--) begin
      if (s_axis.tvalid[p]) begin
        if (p[2:0] > last_grant_q) begin
          found_hi = 1'b1;
          pick_hi  = p[2:0];
        end else begin
          found_lo = 1'b1;
          pick_lo  = p[2:0];
        end
      end
    end
    pick    = found_hi ? pick_hi : pick_lo;
    pick_en = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (pick == p[2:0]) pick_en = port_enable[p];
    end
  end

  // Next state, output-register load/drain and discard pulse
  always_comb begin
    g_valid  = |(s_axis.tvalid & gnt_oh);
    g_last   = |(s_axis.tlast & gnt_oh);
    out_load = !m_tvalid_q || m_axis.tready[0];
    g_ready  = ((state_q == FWD) && out_load) || (state_q == FLUSH);
    beat_acc = g_ready && g_valid;

    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_tvalid_d   = m_tvalid_q && !m_axis.tready[0];
    m_tlast_d    = m_tlast_q;
    m_tdata_d    = m_tdata_q;
    m_tkeep_d    = m_tkeep_q;
    m_tuser_d    = m_tuser_q;
    flush_pulse  = '0;

    case (state_q)
      IDLE: begin
        if (found_hi || found_lo) begin
          grant_d = pick;
          state_d = pick_en ? FWD : FLUSH;
        end
      end
      FWD: begin
        if (beat_acc) begin
          m_tvalid_d = 1'b1;
          m_tlast_d  = g_last;
          m_tdata_d  = sel_tdata;
          m_tkeep_d  = sel_tkeep;
          m_tuser_d  = sel_tuser;
          // one-hot grant is exactly (1 << g), stamped as the source-port tag
          m_tuser_d[SRC_PORT_POS +: 8] = 8'(gnt_oh);
          if (g_last) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
      end
      FLUSH: begin
        if (beat_acc && g_last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          flush_pulse  = gnt_oh;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant bookkeeping and output register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= 3'(NP - 1);
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tdata_q    <= '0;
      m_tkeep_q    <= '0;
      m_tuser_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      m_tdata_q    <= m_tdata_d;
      m_tkeep_q    <= m_tkeep_d;
      m_tuser_q    <= m_tuser_d;
    end
  end

  assign s_axis.tready = gnt_oh & {NP{g_ready}};
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tlast  = m_tlast_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tkeep  = m_tkeep_q;
  assign m_axis.tuser  = m_tuser_q;
  assign grant_port    = grant_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_osnt_rx_port_arbiter.sv
// tb/tb_osnt_rx_port_arbiter.sv - directed scoreboard bench for osnt_rx_port_arbiter
module tb_osnt_rx_port_arbiter;
  localparam int DW  = 64;
  localparam int KW  = DW / 8;
  localparam int UW  = 32;
  localparam int NP  = 4;
  localparam int POS = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    logic          f;
    int            gap;
  } beat_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NP-1:0] port_enable;
  logic [NP-1:0] flush_pulse;
  logic [2:0]    grant_port;
  logic          busy;

  osnt_rx_port_arbiter_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .LANES(NP)) s_if ();
  osnt_rx_port_arbiter_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .LANES(1))  m_if ();

  osnt_rx_port_arbiter #(
    .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW), .NUM_PORTS(NP), .SRC_PORT_POS(POS)
  ) dut (
    .clk(clk), .resetn(resetn), .s_axis(s_if), .m_axis(m_if),
    .port_enable(port_enable), .flush_pulse(flush_pulse),
    .grant_port(grant_port), .busy(busy)
  );

  always #5 clk = ~clk;

  beat_t src_q [NP][$];
  beat_t exp_q [$];
  logic  rdy_q [$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    last_xfer = 0;
  int    xfer_cnt = 0;
  int    pkt_id = 0;
  int    acc_cnt [NP];
  int    flush_seen [NP];
  bit    stall_chk = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_s();
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        s_if.tvalid[p]          = 1'b1;
        s_if.tlast[p]           = src_q[p][0].l;
        s_if.tdata[p*DW +: DW]  = src_q[p][0].d;
        s_if.tkeep[p*KW +: KW]  = src_q[p][0].k;
        s_if.tuser[p*UW +: UW]  = src_q[p][0].u;
      end else begin
        s_if.tvalid[p]          = 1'b0;
        s_if.tlast[p]           = 1'b0;
        s_if.tdata[p*DW +: DW]  = '0;
        s_if.tkeep[p*KW +: KW]  = '0;
        s_if.tuser[p*UW +: UW]  = '0;
      end
    end
  endtask

  task automatic send_pkt(input int port, input int nb, input bit fwd, input bit timed, input int first_gap);
    beat_t b;
    beat_t e;
    pkt_id++;
    for (int i = 0; i < nb; i++) begin
      b.d   = {8'(port), 8'(pkt_id), 16'(i), 32'($urandom)};
      b.k   = (i == nb - 1) ? 8'h0F : 8'hFF;
      b.u   = 32'($urandom);
      b.l   = (i == nb - 1);
      b.f   = fwd;
      b.gap = 0;
      src_q[port].push_back(b);
      if (fwd) begin
        e = b;
        e.u[POS +: 8] = 8'(1 << port);
        e.gap = timed ? ((i == 0) ? first_gap : 1) : 0;
        exp_q.push_back(e);
      end
    end
    drive_s();
  endtask

  task automatic step();
    logic [NP-1:0] acc;
    logic [NP-1:0] exp_fl;
    @(negedge clk);
    cyc++;
    acc    = s_if.tvalid & s_if.tready;
    exp_fl = '0;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        chk("acc_grant", 128'(grant_port), 128'(p));
        chk("acc_busy", 128'(busy), 128'(1));
        if (src_q[p][0].l && !src_q[p][0].f) exp_fl[p] = 1'b1;
      end
      if (flush_pulse[p]) flush_seen[p]++;
    end
    chk("flush_pulse", 128'(flush_pulse), 128'(exp_fl));
    if (stall_chk && m_if.tvalid[0] && !m_if.tready[0])
      chk("stall_s_tready", 128'(s_if.tready), 128'(0));
    if (m_if.tvalid[0]) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 128'(m_if.tvalid), 128'(0));
      end else begin
        chk("m_tdata", 128'(m_if.tdata), 128'(exp_q[0].d));
        if (m_if.tready[0]) begin
          chk("m_tkeep", 128'(m_if.tkeep), 128'(exp_q[0].k));
          chk("m_tuser", 128'(m_if.tuser), 128'(exp_q[0].u));
          chk("m_tlast", 128'(m_if.tlast), 128'(exp_q[0].l));
          if (exp_q[0].gap != 0) chk("beat_gap", 128'(cyc - last_xfer), 128'(exp_q[0].gap));
          last_xfer = cyc;
          xfer_cnt++;
          void'(exp_q.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        void'(src_q[p].pop_front());
        acc_cnt[p]++;
      end
    end
    drive_s();
    m_if.tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
  endtask

  function automatic bit pending();
    bit r;
    r = (exp_q.size() > 0) || busy || m_if.tvalid[0];
    for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic drain(input int max);
    int n;
    n = 0;
    while (pending() && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", 128'(n < max), 128'(1));
    repeat (2) step();
  endtask

  initial begin
    int base;
    int n;
    for (int p = 0; p < NP; p++) begin
      acc_cnt[p]    = 0;
      flush_seen[p] = 0;
    end
    resetn      = 1'b0;
    port_enable = '1;
    m_if.tready = 1'b1;
    drive_s();
    #12;
    chk("rst_m_tvalid", 128'(m_if.tvalid), 128'(0));
    chk("rst_m_tlast", 128'(m_if.tlast), 128'(0));
    chk("rst_m_tdata", 128'(m_if.tdata), 128'(0));
    chk("rst_m_tuser", 128'(m_if.tuser), 128'(0));
    chk("rst_s_tready", 128'(s_if.tready), 128'(0));
    chk("rst_flush", 128'(flush_pulse), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant_port), 128'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // all four ports at once: order 0,1,2,3 with one bubble between packets
    for (int p = 0; p < NP; p++) send_pkt(p, 3, 1'b1, 1'b1, (p == 0) ? 0 : 2);
    drain(200);

    // port 1 alone, back-to-back single-beat packets every other cycle
    for (int k = 0; k < 6; k++) send_pkt(1, 1, 1'b1, 1'b1, (k == 0) ? 0 : 2);
    drain(200);

    // port 1 disabled: its packet is discarded with a single pulse
    port_enable = 4'b1101;
    base = flush_seen[1];
    send_pkt(1, 4, 1'b0, 1'b0, 0);
    send_pkt(2, 4, 1'b1, 1'b1, 0);
    drain(200);
    chk("s3_flush_cnt_p1", 128'(flush_seen[1]), 128'(base + 1));
    chk("s3_flush_cnt_p2", 128'(flush_seen[2]), 128'(0));
    port_enable = '1;

    // downstream stalls during a 5-beat packet
    stall_chk = 1'b1;
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    send_pkt(3, 5, 1'b1, 1'b0, 0);
    drain(200);
    stall_chk = 1'b0;

    // enable cleared mid-packet: current packet forwarded, next one flushed
    base = flush_seen[0];
    n = acc_cnt[0];
    send_pkt(0, 6, 1'b1, 1'b0, 0);
    send_pkt(0, 2, 1'b0, 1'b0, 0);
    while (acc_cnt[0] < n + 2 && cyc < 5000) step();
    chk("s5_wait", 128'(acc_cnt[0] >= n + 2), 128'(1));
    port_enable[0] = 1'b0;
    drain(200);
    chk("s5_flush_cnt_p0", 128'(flush_seen[0]), 128'(base + 1));
    port_enable[0] = 1'b1;

    // reset during beat 3, then port 0 must win over port 2
    n = xfer_cnt;
    send_pkt(0, 5, 1'b1, 1'b0, 0);
    while (xfer_cnt < n + 2 && cyc < 5000) step();
    chk("s6_wait", 128'(xfer_cnt >= n + 2), 128'(1));
    chk("s6_pre_rst_valid", 128'(m_if.tvalid), 128'(1));
    #2;
    resetn = 1'b0;
    #1;
    chk("s6_async_clear", 128'(m_if.tvalid), 128'(0));
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
    drive_s();
    step();
    step();
    resetn = 1'b1;
    chk("s6_grant_after_rst", 128'(grant_port), 128'(0));
    send_pkt(0, 2, 1'b1, 1'b0, 0);
    send_pkt(2, 2, 1'b1, 1'b0, 0);
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
